// File: rtl/aes_mix_pkg.sv
// Shared types and the row-major <-> column mapping for the round-key mixer.
package aes_mix_pkg;

   // Widest state the column helpers accept; callers size-cast in and out.
   localparam int MAX_NCOL = 8;
   localparam int MAX_W    = 32 * MAX_NCOL;

   typedef enum logic {
      MIX_XOR = 1'b0,
      MIX_ADD = 1'b1
   } mix_mode_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } fsm_e;

   // Gather column c: byte b(r,c) sits at byte index r*ncol+c, MSB byte first.
   // Row 0 lands in the word MSB.
   function automatic logic [31:0] get_col(input logic [MAX_W-1:0] st, input int ncol,
                                           input int c);
      logic [31:0] w;
      w = '0;
      for (int r = 0; r < 4; r++)
         w[31-8*r -: 8] = st[ncol*32-1-8*(r*ncol+c) -: 8];
      return w;
   endfunction

   // Scatter a column word back to the same byte positions.
   function automatic logic [MAX_W-1:0] put_col(input logic [MAX_W-1:0] st, input int ncol,
                                                input int c, input logic [31:0] w);
      logic [MAX_W-1:0] o;
      o = st;
      for (int r = 0; r < 4; r++)
         o[ncol*32-1-8*(r*ncol+c) -: 8] = w[31-8*r -: 8];
      return o;
   endfunction

endpackage

// File: rtl/round_key_mix_col.sv
// One column of the mixer: XOR or 32-bit modular add of a key word.
// Carries stay inside the word, so columns never interact.
module round_key_mix_col (
   input  logic        add,
   input  logic [31:0] word,
   input  logic [31:0] key_word,
   output logic [31:0] res
);

   // Pure combinational mix; mode selects add vs xor.
   always_comb begin
      res = add ? (word + key_word) : (word ^ key_word);
   end

endmodule

// File: rtl/round_key_mixer.sv
// Sequential round-key mixer: key bank plus a one-key-per-clock FSM that
// walks a contiguous key range over one captured state block.
module round_key_mixer
   import aes_mix_pkg::*;
#(
   parameter  int NCOL     = 4,
   parameter  int NUM_KEYS = 15,
   localparam int DATA_W   = 32 * NCOL,
   localparam int IDX_W    = $clog2(NUM_KEYS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              key_we,
   input  logic [IDX_W-1:0]  key_waddr,
   input  logic [DATA_W-1:0] key_wdata,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [IDX_W-1:0]  in_first,
   input  logic [IDX_W-1:0]  in_last,
   input  logic              in_mode,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_err
);

   fsm_e                          state_q, state_d;
   logic [DATA_W-1:0]             data_q;
   logic [IDX_W-1:0]              cur_q, last_q;
   mix_mode_e                     mode_q;
   logic                          err_q;
   logic [NUM_KEYS-1:0][DATA_W-1:0] bank;

   logic [DATA_W-1:0]             cur_key;
   logic [NCOL-1:0][31:0]         col_w, mixed_w;
   logic [DATA_W-1:0]             mixed;
   logic                          accept, range_bad, at_last;

   assign accept    = in_valid & in_ready;
   assign range_bad = (in_last < in_first) || (int'(in_last) >= NUM_KEYS);
   assign at_last   = (cur_q == last_q);
   assign cur_key   = bank[cur_q];

   for (genvar c = 0; c < NCOL; c++) begin : g_col
      assign col_w[c] = get_col(MAX_W'(data_q), NCOL, c);
      round_key_mix_col u_col (
         .add      (mode_q == MIX_ADD),
         .word     (col_w[c]),
         .key_word (cur_key[DATA_W-1-32*c -: 32]),
         .res      (mixed_w[c])
      );
   end

   // Reassemble the mixed columns into row-major order.
   always_comb begin
      mixed = data_q;
      for (int c = 0; c < NCOL; c++)
         mixed = DATA_W'(put_col(MAX_W'(mixed), NCOL, c, mixed_w[c]));
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: bad ranges skip RUN and report straight away.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = range_bad ? DONE : RUN;
         RUN:     if (at_last) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; in_ready is held low through reset.
   always_comb begin
      in_ready  = (state_q == IDLE) && !rst;
      out_valid = (state_q == DONE);
   end

   // Datapath: key bank, capture on accept, one key per edge in RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q <= '0;
         cur_q  <= '0;
         last_q <= '0;
         mode_q <= MIX_XOR;
         err_q  <= 1'b0;
         bank   <= '0;
      end else begin
         if (key_we && (int'(key_waddr) < NUM_KEYS))
            bank[key_waddr] <= key_wdata;
         case (state_q)
            IDLE: if (accept) begin
               data_q <= in_data;
               cur_q  <= in_first;
               last_q <= in_last;
               mode_q <= mix_mode_e'(in_mode);
               err_q  <= range_bad;
            end
            RUN: begin
               data_q <= mixed;
               cur_q  <= cur_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign out_data = data_q;
   assign out_err  = err_q;

endmodule
